// File: rtl/lpm_mux_rr_sel.sv
// Round-robin select generator for lpm_mux: holds sel until ack, then rotates; result_valid tracks mux latency.
// Optional burst lock input enabled by defining LPM_MUX_RR_LOCK_EN.
module lpm_mux_rr_sel #(
   parameter     lpm_type     = "lpm_mux_rr_sel",
   parameter int lpm_size     = 4,
   parameter int lpm_widths   = 2,
   parameter int lpm_pipeline = 0,
   parameter     lpm_hint     = "UNUSED"
) (
   input  logic                  clock,
   input  logic                  aclrn,
   input  logic                  clken,
   input  logic [lpm_size-1:0]   req,
   input  logic                  ack,
`ifdef LPM_MUX_RR_LOCK_EN
   input  logic                  lock,
`endif
   output logic [lpm_widths-1:0] sel,
   output logic [lpm_size-1:0]   grant,
   output logic                  grant_valid,
   output logic                  result_valid
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                state_q, state_d;
   logic [lpm_widths-1:0] sel_q, sel_d;
   logic [lpm_size-1:0]   grant_q, grant_d;
   logic [lpm_widths-1:0] last_q, last_d;
   logic [lpm_widths-1:0] base, winner;
   logic [lpm_size-1:0]   req_shift;
   logic                  cur_req;
   logic                  lock_hold;
   logic                  unused_params;

   assign unused_params = ^{lpm_type, lpm_hint};

`ifdef LPM_MUX_RR_LOCK_EN
   assign lock_hold = lock;
`else
   assign lock_hold = 1'b0;
`endif

   // First requester strictly after ptr, wrapping modulo lpm_size.
   function automatic logic [lpm_widths-1:0] rr_pick(input logic [lpm_widths-1:0] ptr,
                                                     input logic [lpm_size-1:0]   r);
      logic [lpm_widths-1:0] w;
      logic [lpm_size-1:0]   rs;
      int                    idx;
      w = '0;
      for (int k = lpm_size; k >= 1; k--) begin
         idx = int'(ptr) + k;
         if (idx >= lpm_size) idx = idx - lpm_size;
         rs = r >> idx;
         if (rs[0]) w = lpm_widths'(idx);
      end
      return w;
   endfunction

   assign req_shift = req >> sel_q;
   assign cur_req   = req_shift[0];
   assign base      = (state_q == GRANT) ? sel_q : last_q;
   assign winner    = rr_pick(base, req);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      grant_d = grant_q;
      last_d  = last_q;
      if (clken) begin
         case (state_q)
            IDLE: begin
               if (|req) begin
                  sel_d   = winner;
                  grant_d = lpm_size'(1) << winner;
                  state_d = GRANT;
               end
            end
            GRANT: begin
               // A locked ack keeps the grant only while the owner still requests.
               if (ack && !(lock_hold && cur_req)) begin
                  last_d = sel_q;
                  if (|req) begin
                     sel_d   = winner;
                     grant_d = lpm_size'(1) << winner;
                  end else begin
                     state_d = IDLE;
                     sel_d   = '0;
                     grant_d = '0;
                  end
               end else if (!cur_req) begin
                  state_d = IDLE;
                  sel_d   = '0;
                  grant_d = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge aclrn) begin
      if (!aclrn) begin
         state_q <= IDLE;
         sel_q   <= '0;
         grant_q <= '0;
         last_q  <= lpm_widths'(lpm_size - 1);
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   assign sel         = sel_q;
   assign grant       = grant_q;
   assign grant_valid = (state_q == GRANT);

   generate
      if (lpm_pipeline == 0) begin : g_no_delay
         assign result_valid = grant_valid;
      end else begin : g_delay
         logic [lpm_pipeline-1:0] dly_q, dly_d;

         always_comb begin
            dly_d = dly_q;
            if (clken) dly_d = (dly_q << 1) | lpm_pipeline'(grant_valid);
         end

         always_ff @(posedge clock or negedge aclrn) begin
            if (!aclrn) dly_q <= '0;
            else        dly_q <= dly_d;
         end

         assign result_valid = dly_q[lpm_pipeline-1];
      end
   endgenerate

endmodule

// File: tb/tb_lpm_mux_rr_sel.sv
// Directed bench for lpm_mux_rr_sel (lpm_size=4, lpm_pipeline=2); expectations queued per step, checked after the edge.
module tb_lpm_mux_rr_sel;

   typedef struct packed {
      logic [1:0] sel;
      logic [3:0] grant;
      logic       gv;
      logic       rv;
   } exp_t;

   logic       clk = 1'b0;
   logic       aclrn;
   logic       clken;
   logic [3:0] req;
   logic       ack;
`ifdef LPM_MUX_RR_LOCK_EN
   logic       lock;
`endif
   logic [1:0] sel;
   logic [3:0] grant;
   logic       grant_valid;
   logic       result_valid;

   exp_t  exp_q[$];
   string tag_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   always #5 clk = ~clk;

   lpm_mux_rr_sel #(
      .lpm_size    (4),
      .lpm_widths  (2),
      .lpm_pipeline(2)
   ) dut (
      .clock       (clk),
      .aclrn       (aclrn),
      .clken       (clken),
      .req         (req),
      .ack         (ack),
`ifdef LPM_MUX_RR_LOCK_EN
      .lock        (lock),
`endif
      .sel         (sel),
      .grant       (grant),
      .grant_valid (grant_valid),
      .result_valid(result_valid)
   );

   task automatic push_exp(input string t, input logic [1:0] es, input logic [3:0] eg,
                           input logic egv, input logic erv);
      exp_t e;
      e.sel = es; e.grant = eg; e.gv = egv; e.rv = erv;
      exp_q.push_back(e);
      tag_q.push_back(t);
   endtask

   task automatic pop_check();
      exp_t  e;
      string t;
      n_cmp++;
      assert (exp_q.size() > 0) else begin
         n_bad++;
         $error("FAIL scoreboard_empty got %0d entries want >0", exp_q.size());
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         n_cmp++;
         assert (sel === e.sel) else begin
            n_bad++; $error("FAIL %s sel got %0d want %0d", t, sel, e.sel);
         end
         n_cmp++;
         assert (grant === e.grant) else begin
            n_bad++; $error("FAIL %s grant got %b want %b", t, grant, e.grant);
         end
         n_cmp++;
         assert (grant_valid === e.gv) else begin
            n_bad++; $error("FAIL %s grant_valid got %b want %b", t, grant_valid, e.gv);
         end
         n_cmp++;
         assert (result_valid === e.rv) else begin
            n_bad++; $error("FAIL %s result_valid got %b want %b", t, result_valid, e.rv);
         end
         $display("%s: req=%b ack=%b clken=%b sel=%0d grant=%b gv=%b rv=%b",
                  t, req, ack, clken, sel, grant, grant_valid, result_valid);
      end
   endtask

   // One enabled/disabled clock: drive at negedge, expect after the next rising edge.
   task automatic step(input string t, input logic [3:0] r, input logic a, input logic ce,
                       input logic l, input logic [1:0] es, input logic [3:0] eg,
                       input logic egv, input logic erv);
      @(negedge clk);
      req = r; ack = a; clken = ce;
`ifdef LPM_MUX_RR_LOCK_EN
      lock = l;
`else
      if (l) $display("%s: lock requested but not built in", t);
`endif
      push_exp(t, es, eg, egv, erv);
      @(posedge clk);
      #1;
      pop_check();
   endtask

   // Assert reset between edges and check outputs clear without any clock edge.
   task automatic reset_check(input string t);
      @(negedge clk);
      aclrn = 1'b0;
      #1;
      push_exp(t, 2'd0, 4'b0000, 1'b0, 1'b0);
      pop_check();
      @(negedge clk);
      aclrn = 1'b1; req = 4'b0000; ack = 1'b0; clken = 1'b1;
`ifdef LPM_MUX_RR_LOCK_EN
      lock = 1'b0;
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      aclrn = 1'b0; clken = 1'b1; req = 4'b1111; ack = 1'b0;
`ifdef LPM_MUX_RR_LOCK_EN
      lock = 1'b0;
`endif
      #2;
      push_exp("rst_hold", 2'd0, 4'b0000, 1'b0, 1'b0);
      pop_check();
      @(posedge clk); #1;
      push_exp("rst_edge", 2'd0, 4'b0000, 1'b0, 1'b0);
      pop_check();
      @(negedge clk);
      aclrn = 1'b1; req = 4'b0000;

      // idle after reset
      step("A1_idle", 4'b0000, 0, 1, 0, 2'd0, 4'b0000, 0, 0);
      step("A2_idle", 4'b0000, 0, 1, 0, 2'd0, 4'b0000, 0, 0);

      // full rotation with ack every cycle; result_valid lags by 2
      step("B1_first",  4'b1111, 0, 1, 0, 2'd0, 4'b0001, 1, 0);
      step("B2_rot",    4'b1111, 1, 1, 0, 2'd1, 4'b0010, 1, 0);
      step("B3_rot",    4'b1111, 1, 1, 0, 2'd2, 4'b0100, 1, 1);
      step("B4_rot",    4'b1111, 1, 1, 0, 2'd3, 4'b1000, 1, 1);
      step("B5_wrap",   4'b1111, 1, 1, 0, 2'd0, 4'b0001, 1, 1);
      step("B6_rot",    4'b1111, 1, 1, 0, 2'd1, 4'b0010, 1, 1);
      step("B7_lastack",4'b0000, 1, 1, 0, 2'd0, 4'b0000, 0, 1);
      step("B8_rvtail", 4'b0000, 0, 1, 0, 2'd0, 4'b0000, 0, 1);
      step("B9_rvfall", 4'b0000, 0, 1, 0, 2'd0, 4'b0000, 0, 0);

      // single requester regranted after each ack, then withdrawal
      step("C1_grant2", 4'b0100, 0, 1, 0, 2'd2, 4'b0100, 1, 0);
      step("C2_hold",   4'b0100, 0, 1, 0, 2'd2, 4'b0100, 1, 0);
      step("C3_ack",    4'b0100, 1, 1, 0, 2'd2, 4'b0100, 1, 1);
      step("C4_hold",   4'b0100, 0, 1, 0, 2'd2, 4'b0100, 1, 1);
      step("C5_hold",   4'b0100, 0, 1, 0, 2'd2, 4'b0100, 1, 1);
      step("C6_ack",    4'b0100, 1, 1, 0, 2'd2, 4'b0100, 1, 1);
      step("C7_withdr", 4'b0000, 0, 1, 0, 2'd0, 4'b0000, 0, 1);
      step("C8_tail",   4'b0000, 0, 1, 0, 2'd0, 4'b0000, 0, 1);
      step("C9_tail",   4'b0000, 0, 1, 0, 2'd0, 4'b0000, 0, 0);

      // clken stall shifts the result_valid rise by one cycle
      step("D1_grant1", 4'b0010, 0, 1, 0, 2'd1, 4'b0010, 1, 0);
      step("D2_frozen", 4'b0010, 1, 0, 0, 2'd1, 4'b0010, 1, 0);
      step("D3_hold",   4'b0010, 0, 1, 0, 2'd1, 4'b0010, 1, 0);
      step("D4_rvrise", 4'b0010, 0, 1, 0, 2'd1, 4'b0010, 1, 1);

      // async reset mid-grant; last_ptr returns to 3
      reset_check("D5_midrst");
      step("D6_regrant",4'b0010, 0, 1, 0, 2'd1, 4'b0010, 1, 0);
      step("D7_frzack", 4'b0010, 1, 0, 0, 2'd1, 4'b0010, 1, 0);
      step("D8_rot",    4'b1111, 1, 1, 0, 2'd2, 4'b0100, 1, 0);
      step("D9_idle",   4'b0000, 1, 1, 0, 2'd0, 4'b0000, 0, 1);
      step("D10_tail",  4'b0000, 0, 1, 0, 2'd0, 4'b0000, 0, 1);
      step("D11_tail",  4'b0000, 0, 1, 0, 2'd0, 4'b0000, 0, 0);
      step("D12_idleack",4'b0000,1, 1, 0, 2'd0, 4'b0000, 0, 0);
      step("D13_after2",4'b1111, 0, 1, 0, 2'd3, 4'b1000, 1, 0);
      step("D14_sole3", 4'b1000, 1, 1, 0, 2'd3, 4'b1000, 1, 0);
      step("D15_withdr",4'b0000, 0, 1, 0, 2'd0, 4'b0000, 0, 1);
      step("D16_wrap0", 4'b0001, 0, 1, 0, 2'd0, 4'b0001, 1, 1);
      step("D17_ackdrop",4'b0010,1, 1, 0, 2'd1, 4'b0010, 1, 0);
      step("D18_withdr",4'b0000, 0, 1, 0, 2'd0, 4'b0000, 0, 1);
      step("D19_tail",  4'b0000, 0, 1, 0, 2'd0, 4'b0000, 0, 1);
      step("D20_tail",  4'b0000, 0, 1, 0, 2'd0, 4'b0000, 0, 0);

`ifdef LPM_MUX_RR_LOCK_EN
      // burst lock keeps requester 0 across three acks
      reset_check("L0_rst");
      step("L1_grant0", 4'b1111, 0, 1, 0, 2'd0, 4'b0001, 1, 0);
      step("L2_lock",   4'b1111, 1, 1, 1, 2'd0, 4'b0001, 1, 0);
      step("L3_lock",   4'b1111, 1, 1, 1, 2'd0, 4'b0001, 1, 1);
      step("L4_lock",   4'b1111, 1, 1, 1, 2'd0, 4'b0001, 1, 1);
      step("L5_unlock", 4'b1111, 1, 1, 0, 2'd1, 4'b0010, 1, 1);
      step("L6_withdr", 4'b0000, 0, 1, 0, 2'd0, 4'b0000, 0, 1);
      step("L7_grant2", 4'b0100, 0, 1, 0, 2'd2, 4'b0100, 1, 1);
      step("L8_lockwd", 4'b0000, 1, 1, 1, 2'd0, 4'b0000, 0, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
